// File: rtl/mp_regfile.sv
// mp_regfile: multi-ported register file with same-cycle write bypass
// and a per-register pending-writer scoreboard.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   wr_en/addr/data    NWR write ports; on an address clash the highest index wins
//   rd_addr/data       NRD combinational read ports, bypassing same-cycle writes
//   rd_busy            per read port: a pending writer exists (cleared by bypass)
//   alc_en/addr        NWR scoreboard allocate ports (mark register pending)
//   flush              clear every pending mark on the next edge
//   busy_vec           registered scoreboard bits, no bypass applied
module mp_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 4,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NWR-1:0]                  wr_en,
  input  logic [NWR*$clog2(NREG)-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0]           wr_data,
  input  logic [NRD*$clog2(NREG)-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0]           rd_data,
  output logic [NRD-1:0]                  rd_busy,
  input  logic [NWR-1:0]                  alc_en,
  input  logic [NWR*$clog2(NREG)-1:0]     alc_addr,
  input  logic                            flush,
  output logic [NREG-1:0]                 busy_vec
);

  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [NWR-1:0]    wen;
  logic [NWR-1:0]    aen;

  // Effective enables: with a hardwired zero register, traffic
  // to index 0 is dropped here so storage, bypass and the
  // scoreboard never see it.
  always_comb begin
    wen = '0;
    aen = '0;
    for (int p = 0; p < NWR; p++) begin
      wen[p] = wr_en[p] &&
               !(ZERO_REG != 0 &&
                 wr_addr[p*AW +: AW] == '0);
      aen[p] = alc_en[p] &&
               !(ZERO_REG != 0 &&
                 alc_addr[p*AW +: AW] == '0);
    end
  end

  // Later ports are applied last, so the highest index wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        mem[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (wen[p])
          mem[wr_addr[p*AW +: AW]] <=
            wr_data[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic              hit;
      logic [DATA_W-1:0] val;
      hit = 1'b0;
      val = mem[rd_addr[i*AW +: AW]];
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] &&
            wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW]) begin
          hit = 1'b1;
          val = wr_data[p*DATA_W +: DATA_W];
        end
      end
      if (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0)
        val = '0;
      rd_data[i*DATA_W +: DATA_W] = val;
      // A value arriving this cycle is forwarded, so not busy.
      rd_busy[i] = busy[rd_addr[i*AW +: AW]] && !hit;
    end
  end

  // Allocates are applied after write clears: a new producer
  // supersedes the one completing in the same cycle.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NWR; p++)
      if (wen[p])
        busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
    for (int p = 0; p < NWR; p++)
      if (aen[p])
        busy_nxt[alc_addr[p*AW +: AW]] = 1'b1;
    if (flush)
      busy_nxt = '0;
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_mp_regfile.sv
// tb_mp_regfile: directed and random checks of mp_regfile against
// an array-based reference model, plus a ZERO_REG=0 instance.
module tb_mp_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic [3:0]   rd_busy;
  logic [1:0]   alc_en;
  logic [9:0]   alc_addr;
  logic         flush;
  logic [31:0]  busy_vec;

  logic         b_rst;
  logic [0:0]   b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [31:0]  b_wr_data;
  logic [7:0]   b_rd_addr;
  logic [63:0]  b_rd_data;
  logic [1:0]   b_rd_busy;
  logic [0:0]   b_alc_en;
  logic [3:0]   b_alc_addr;
  logic         b_flush;
  logic [15:0]  b_busy_vec;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  mp_regfile dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .alc_en(alc_en), .alc_addr(alc_addr), .flush(flush),
    .busy_vec(busy_vec)
  );

  mp_regfile #(
    .DATA_W(32), .NREG(16), .NRD(2), .NWR(1), .ZERO_REG(0)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .alc_en(b_alc_en), .alc_addr(b_alc_addr), .flush(b_flush),
    .busy_vec(b_busy_vec)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int wa(int p);
    return int'(wr_addr[p*5 +: 5]);
  endfunction

  // Reference read: youngest matching write this cycle, else the
  // architectural value; index 0 always reads 0.
  function automatic logic [31:0] exp_rd(int a);
    logic [31:0] r;
    r = (a == 0) ? 32'h0 : m_reg[a];
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && a != 0 && wa(p) == a)
        r = wr_data[p*32 +: 32];
    return r;
  endfunction

  function automatic logic exp_hit(int a);
    logic h;
    h = 1'b0;
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && a != 0 && wa(p) == a)
        h = 1'b1;
    return h;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int a;
      a = int'(rd_addr[i*5 +: 5]);
      chk("rd_data", 64'(rd_data[i*32 +: 32]), 64'(exp_rd(a)));
      chk("rd_busy", 64'(rd_busy[i]),
          64'(m_busy[a] && !exp_hit(a)));
    end
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  task automatic model_edge();
    logic [31:0] nb;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
      m_busy = '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wa(p) != 0)
          m_reg[wa(p)] = wr_data[p*32 +: 32];
      nb = m_busy;
      for (int r = 1; r < 32; r++) begin
        logic set, clr;
        set = 1'b0;
        clr = 1'b0;
        for (int p = 0; p < 2; p++) begin
          if (alc_en[p] && int'(alc_addr[p*5 +: 5]) == r) set = 1'b1;
          if (wr_en[p] && wa(p) == r) clr = 1'b1;
        end
        if (set) nb[r] = 1'b1;
        else if (clr) nb[r] = 1'b0;
      end
      m_busy = flush ? 32'h0 : nb;
    end
  endtask

  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;
    wr_en = '0;
    alc_en = '0;
    flush = 1'b0;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ?
      5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; alc_en = '0; alc_addr = '0; flush = 1'b0;
    b_rst = 1'b1; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_addr = '0; b_alc_en = '0; b_alc_addr = '0; b_flush = 1'b0;
    repeat (2) @(posedge clk);
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_busy = '0;
    @(negedge clk);
    rst = 1'b0;
    b_rst = 1'b0;

    // all indices read zero after reset
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++)
        rd_addr[i*5 +: 5] = 5'(k*4 + i);
      #1;
      chk("rst_rd", 64'(rd_data), 64'h0);
      chk("rst_busy", 64'(busy_vec), 64'h0);
      cyc();
    end

    // dual write same register: port 1 wins
    wr_en = 2'b11;
    wr_addr = {5'd5, 5'd5};
    wr_data = {32'h22222222, 32'h11111111};
    rd_addr = {5'd0, 5'd0, 5'd0, 5'd5};
    #1;
    chk("byp_r5", 64'(rd_data[31:0]), 64'h22222222);
    cyc();
    #1;
    chk("st_r5", 64'(rd_data[31:0]), 64'h22222222);
    cyc();

    // r0 hardwired
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'hDEADBEEF};
    alc_en = 2'b01;
    alc_addr = {5'd0, 5'd0};
    rd_addr = '0;
    #1;
    chk("r0_byp", 64'(rd_data[31:0]), 64'h0);
    cyc();
    #1;
    chk("r0_st", 64'(rd_data[31:0]), 64'h0);
    chk("r0_busy", 64'(busy_vec[0]), 64'h0);
    cyc();

    // allocate r7, then complete it three cycles later
    alc_en = 2'b01;
    alc_addr = {5'd0, 5'd7};
    rd_addr = {5'd0, 5'd0, 5'd0, 5'd7};
    #1;
    chk("alc_same", 64'(rd_busy[0]), 64'h0);
    cyc();
    #1;
    chk("alc_n1", 64'(busy_vec[7]), 64'h1);
    chk("alc_rdb", 64'(rd_busy[0]), 64'h1);
    cyc();
    cyc();
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd7};
    wr_data = {32'h0, 32'hA5};
    #1;
    chk("wr7_busy", 64'(rd_busy[0]), 64'h0);
    chk("wr7_data", 64'(rd_data[31:0]), 64'hA5);
    cyc();
    #1;
    chk("wr7_clr", 64'(busy_vec[7]), 64'h0);
    cyc();

    // allocate beats write; flush beats allocate
    alc_en = 2'b01;
    alc_addr = {5'd0, 5'd9};
    wr_en = 2'b10;
    wr_addr = {5'd9, 5'd0};
    wr_data = {32'h99, 32'h0};
    cyc();
    #1;
    chk("alc_wr9", 64'(busy_vec[9]), 64'h1);
    flush = 1'b1;
    alc_en = 2'b10;
    alc_addr = {5'd3, 5'd0};
    rd_addr = {5'd0, 5'd0, 5'd0, 5'd9};
    cyc();
    #1;
    chk("flush_bv", 64'(busy_vec), 64'h0);
    chk("flush_r9", 64'(rd_data[31:0]), 64'h99);
    cyc();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      wr_en = 2'($urandom);
      alc_en = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        wr_addr[p*5 +: 5] = raddr();
        alc_addr[p*5 +: 5] = raddr();
        wr_data[p*32 +: 32] = $urandom;
      end
      for (int i = 0; i < 4; i++)
        rd_addr[i*5 +: 5] = raddr();
      cyc();
    end

    // ZERO_REG=0 instance: r0 is ordinary storage
    b_wr_en = 1'b1;
    b_wr_addr = 4'd0;
    b_wr_data = 32'h5;
    b_alc_en = 1'b1;
    b_alc_addr = 4'd0;
    b_rd_addr = {4'd3, 4'd0};
    #1;
    chk("b_r0_byp", 64'(b_rd_data[31:0]), 64'h5);
    chk("b_rdb0", 64'(b_rd_busy), 64'h0);
    @(negedge clk);
    b_wr_en = 1'b0;
    b_alc_addr = 4'd3;
    #1;
    chk("b_r0_st", 64'(b_rd_data[31:0]), 64'h5);
    chk("b_bv0", 64'(b_busy_vec), 64'h0001);
    chk("b_rdb1", 64'(b_rd_busy[0]), 64'h1);
    @(negedge clk);
    b_alc_en = 1'b0;
    b_rst = 1'b1;
    #1;
    chk("b_bv1", 64'(b_busy_vec), 64'h0009);
    @(negedge clk);
    b_rst = 1'b0;
    #1;
    chk("b_rst_rd", 64'(b_rd_data), 64'h0);
    chk("b_rst_bv", 64'(b_busy_vec), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mp_regfile.md
MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each register in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning the register count, a power of 2 with a minimum of 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 4, meaning the number of read ports.
REQ-004 SHALL have parameter NWR, default 2, meaning the number of write ports and of scoreboard allocate ports.
REQ-005 SHALL have parameter ZERO_REG, default 1, meaning that when it is 1, register 0 is hardwired to zero.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR x AW  write register index
- wr_data  in  NWR x DATA_W  write data
- rd_addr  in  NRD x AW  read register index
- rd_data  out  NRD x DATA_W  read data (combinational)
- rd_busy  out  NRD  a pending writer exists for rd_addr
- alc_en  in  NWR  scoreboard allocate enable
- alc_addr  in  NWR x AW  register index to mark pending
- flush  in  1  clear all pending marks
- busy_vec  out  NREG  scoreboard state

Function
REQ-007 Storage SHALL be NREG x DATA_W flops written on the rising edge of clk; writes SHALL become architecturally visible from the next cycle.
REQ-008 On the same edge, when two or more enabled write ports target one address, the highest-indexed port SHALL win.
REQ-009 Read bypass: rd_data[i] SHALL return wr_data of the highest-indexed enabled write port whose wr_addr matches rd_addr[i] in the same cycle; with no match it SHALL return the stored value.
REQ-010 When ZERO_REG=1:
- writes to index 0 SHALL be ignored, for storage and for bypass;
- reads of index 0 SHALL return 0;
- index 0 SHALL never be marked busy.
REQ-011 When ZERO_REG=0, index 0 SHALL behave like any other register.
REQ-012 The scoreboard SHALL hold one busy bit per register, updated at the clock edge.
REQ-013 Busy-bit update precedence, highest first: rst, flush, alc_en match (set), wr_en match (clear), hold.
REQ-014 An allocate and a write to the same register in the same cycle SHALL leave the bit set, because the new producer supersedes the old one.
REQ-015 Multiple allocate ports naming the same register SHALL set the bit once, with no error.
REQ-016 rd_busy[i] SHALL be busy[rd_addr[i]] AND NOT (any enabled write matching rd_addr[i] this cycle), so a bypassed value reports not-busy.
REQ-017 Same-cycle allocates SHALL NOT affect rd_busy until the next cycle.
REQ-018 flush SHALL clear every busy bit on the next edge and SHALL NOT alter register contents; writes in the flush cycle SHALL still update storage.
REQ-019 busy_vec SHALL equal the registered busy bits, with no bypass applied.
REQ-020 Read latency SHALL be 0 cycles, combinational from rd_addr, wr_*, and state.
REQ-021 Scoreboard-set latency SHALL be 1 cycle.

Reset
REQ-022 While rst=1 at an edge, all registers SHALL become 0 and all busy bits SHALL become 0; wr_en, alc_en and flush SHALL be ignored on that edge.
REQ-023 After reset, rd_data SHALL be 0 and rd_busy SHALL be 0 for every port until the first write or allocate, bypass excepted.
REQ-024 Reset asserted mid-operation SHALL discard pending marks and register contents on that same edge, with no partial retention.

Verification
REQ-025 The bench SHALL cover the following directed scenarios with the default parameters:
- Reset, then read all 32 indices on all ports -> all rd_data=0, busy_vec=0.
- wr port0 r5=0x11111111 and wr port1 r5=0x22222222 in the same cycle, rd r5 -> same cycle 0x22222222 (bypass); next cycle stored 0x22222222.
- wr r0=0xDEADBEEF, rd r0 -> 0 both the same and the next cycle; alc r0 -> busy_vec[0] stays 0.
- alc r7 at cycle N -> busy_vec[7]=1 at N+1; wr r7=0xA5 at N+3 -> rd_busy for r7=0 at N+3 with rd_data=0xA5; busy_vec[7]=0 at N+4.
- alc r9 and wr r9 in the same cycle -> busy_vec[9]=1 next cycle; flush with alc r3 in the same cycle -> busy_vec=0 next cycle, and r9 contents retained.
- ZERO_REG=0, NREG=16, NRD=2, NWR=1: wr r0=0x5 -> rd r0=0x5 next cycle; rst mid-sequence -> r0=0 and busy_vec=0 on the following cycle.
